// File: rtl/lsu_mem_arbiter_pkg.sv
// Shared types and constants for the LSU memory arbiter.
// FSM state encodings and the bit positions of the individual error causes
// that feed the sticky arb_err flag.
package lsu_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_RESP  = 2'd2
    } arb_state_e;

    // Error cause bit positions inside the per-cycle cause vector
    localparam int ERR_SPURIOUS_ACK = 0;
    localparam int ERR_TAG_MISMATCH = 1;
    localparam int ERR_RD_WR_BOTH   = 2;
    localparam int ERR_TIMEOUT      = 3;
    localparam int ERR_W            = 4;

    // Index width for a requester count, never below one bit
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lsu_mem_arbiter_picker.sv
// Combinational round-robin priority picker.
// Returns the first pending requester at or after rr_ptr, wrapping around,
// both as a one-hot vector and as a binary index.
module lsu_rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] pending,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_vld
);

    logic [IDX_W-1:0]   cand_idx [NUM_REQ];
    logic [NUM_REQ-1:0] cand_hit;

    // Candidate at priority offset gi is requester (rr_ptr + gi) mod NUM_REQ
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
        logic [IDX_W:0] sum;
        assign sum          = {1'b0, rr_ptr} + (IDX_W+1)'(gi);
        assign cand_idx[gi] = (sum >= (IDX_W+1)'(NUM_REQ)) ?
                              IDX_W'(sum - (IDX_W+1)'(NUM_REQ)) : sum[IDX_W-1:0];
        assign cand_hit[gi] = pending[cand_idx[gi]];
    end

    // Lowest offset with a pending request wins
    always_comb begin
        grant_idx = '0;
        grant_vld = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (cand_hit[k]) begin
                grant_idx = cand_idx[k];
                grant_vld = 1'b1;
            end
        end
        grant = grant_vld ? (NUM_REQ'(1) << grant_idx) : '0;
    end

endmodule

// File: rtl/lsu_mem_arbiter.sv
// Round-robin arbiter sharing one memory port among NUM_REQ LSUs with a
// single outstanding transaction. The winner's request is captured in IDLE,
// held on mem_* through GRANT until mem_ack, and answered in a one-cycle RESP.
// Optional GRANT watchdog: define LSU_ARB_TIMEOUT_EN.
module lsu_mem_arbiter
    import lsu_mem_arbiter_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TAG_W          = 7,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_rd_en,
    input  logic [NUM_REQ-1:0]        req_wr_en,
    input  logic [NUM_REQ-1:0]        req_gm_or_lds,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wr_data,
    input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
    output logic [NUM_REQ-1:0]        req_ack,
    output logic [DATA_W-1:0]         req_rd_data,
    output logic [TAG_W-1:0]          req_tag_resp,
    output logic                      mem_rd_en,
    output logic                      mem_wr_en,
    output logic                      mem_gm_or_lds,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wr_data,
    output logic [TAG_W-1:0]          mem_tag_req,
    input  logic                      mem_ack,
    input  logic [DATA_W-1:0]         mem_rd_data,
    input  logic [TAG_W-1:0]          mem_tag_resp,
    output logic                      arb_busy,
    output logic                      arb_err
);

    localparam int IDX_W = idx_width(NUM_REQ);

    arb_state_e          state_reg, state_next;
    logic [IDX_W-1:0]    rr_ptr_reg, rr_ptr_next;
    logic [IDX_W-1:0]    winner_reg, winner_next;
    logic [NUM_REQ-1:0]  mask_reg, mask_next;
    logic                mem_rd_reg, mem_rd_next;
    logic                mem_wr_reg, mem_wr_next;
    logic                mem_gm_reg, mem_gm_next;
    logic [ADDR_W-1:0]   mem_addr_reg, mem_addr_next;
    logic [DATA_W-1:0]   mem_data_reg, mem_data_next;
    logic [TAG_W-1:0]    mem_tag_reg, mem_tag_next;
    logic [DATA_W-1:0]   resp_data_reg, resp_data_next;
    logic [TAG_W-1:0]    resp_tag_reg, resp_tag_next;
    logic                err_reg, err_next;
    logic [ERR_W-1:0]    err_cause;
    logic                timeout_hit;

    logic [ADDR_W-1:0]   addr_arr [NUM_REQ];
    logic [DATA_W-1:0]   data_arr [NUM_REQ];
    logic [TAG_W-1:0]    tag_arr  [NUM_REQ];
    logic [NUM_REQ-1:0]  pending;
    logic [NUM_REQ-1:0]  pick_onehot;
    logic [IDX_W-1:0]    pick_idx;
    logic                pick_vld;

    // Unpack the per-requester buses
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign addr_arr[gi] = req_addr[gi*ADDR_W +: ADDR_W];
        assign data_arr[gi] = req_wr_data[gi*DATA_W +: DATA_W];
        assign tag_arr[gi]  = req_tag[gi*TAG_W +: TAG_W];
    end

    assign pending = (req_rd_en | req_wr_en) & ~mask_reg;

    lsu_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .pending   (pending),
        .rr_ptr    (rr_ptr_reg),
        .grant     (pick_onehot),
        .grant_idx (pick_idx),
        .grant_vld (pick_vld)
    );

`ifdef LSU_ARB_TIMEOUT_EN
    localparam int TMO_W = ($clog2(TIMEOUT_CYCLES + 1) > 10) ? $clog2(TIMEOUT_CYCLES + 1) : 10;
    logic [TMO_W-1:0] tmo_cnt_reg;

    // Watchdog counts GRANT cycles without an ack, restarts outside GRANT
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt_reg <= '0;
        end else if (state_reg == ST_GRANT && !mem_ack) begin
            tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
        end else begin
            tmo_cnt_reg <= '0;
        end
    end

    assign timeout_hit = (state_reg == ST_GRANT) && !mem_ack &&
                         (tmo_cnt_reg == TMO_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // State and datapath registers; reset aborts any transaction in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            rr_ptr_reg    <= '0;
            winner_reg    <= '0;
            mask_reg      <= '0;
            mem_rd_reg    <= 1'b0;
            mem_wr_reg    <= 1'b0;
            mem_gm_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_data_reg  <= '0;
            mem_tag_reg   <= '0;
            resp_data_reg <= '0;
            resp_tag_reg  <= '0;
            err_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            rr_ptr_reg    <= rr_ptr_next;
            winner_reg    <= winner_next;
            mask_reg      <= mask_next;
            mem_rd_reg    <= mem_rd_next;
            mem_wr_reg    <= mem_wr_next;
            mem_gm_reg    <= mem_gm_next;
            mem_addr_reg  <= mem_addr_next;
            mem_data_reg  <= mem_data_next;
            mem_tag_reg   <= mem_tag_next;
            resp_data_reg <= resp_data_next;
            resp_tag_reg  <= resp_tag_next;
            err_reg       <= err_next;
        end
    end

    // Next-state logic: capture in IDLE, wait for ack in GRANT, answer in RESP
    always_comb begin
        state_next     = state_reg;
        rr_ptr_next    = rr_ptr_reg;
        winner_next    = winner_reg;
        mask_next      = mask_reg;
        mem_rd_next    = mem_rd_reg;
        mem_wr_next    = mem_wr_reg;
        mem_gm_next    = mem_gm_reg;
        mem_addr_next  = mem_addr_reg;
        mem_data_next  = mem_data_reg;
        mem_tag_next   = mem_tag_reg;
        resp_data_next = resp_data_reg;
        resp_tag_next  = resp_tag_reg;
        err_cause      = '0;

        case (state_reg)
            ST_IDLE: begin
                mask_next                   = '0;
                err_cause[ERR_SPURIOUS_ACK] = mem_ack;
                if (pick_vld) begin
                    winner_next   = pick_idx;
                    mem_addr_next = addr_arr[pick_idx];
                    mem_data_next = data_arr[pick_idx];
                    mem_tag_next  = tag_arr[pick_idx];
                    mem_gm_next   = req_gm_or_lds[pick_idx];
                    // A request with both strobes set is forwarded as a write
                    mem_wr_next   = req_wr_en[pick_idx];
                    mem_rd_next   = req_rd_en[pick_idx] & ~req_wr_en[pick_idx];
                    err_cause[ERR_RD_WR_BOTH] = req_rd_en[pick_idx] & req_wr_en[pick_idx];
                    state_next    = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (mem_ack) begin
                    resp_data_next = mem_rd_data;
                    resp_tag_next  = mem_tag_resp;
                    mem_rd_next    = 1'b0;
                    mem_wr_next    = 1'b0;
                    err_cause[ERR_TAG_MISMATCH] = (mem_tag_resp != mem_tag_reg);
                    state_next     = ST_RESP;
                end else if (timeout_hit) begin
                    resp_data_next = '0;
                    resp_tag_next  = mem_tag_reg;
                    mem_rd_next    = 1'b0;
                    mem_wr_next    = 1'b0;
                    err_cause[ERR_TIMEOUT] = 1'b1;
                    state_next     = ST_RESP;
                end
            end
            ST_RESP: begin
                err_cause[ERR_SPURIOUS_ACK] = mem_ack;
                rr_ptr_next = (winner_reg == IDX_W'(NUM_REQ - 1)) ? '0 : winner_reg + 1'b1;
                // Hide the just-served requester while its request drops
                mask_next   = NUM_REQ'(1) << winner_reg;
                state_next  = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        err_next = err_reg | (|err_cause);
    end

    assign req_ack       = (state_reg == ST_RESP) ? (NUM_REQ'(1) << winner_reg) : '0;
    assign req_rd_data   = resp_data_reg;
    assign req_tag_resp  = resp_tag_reg;
    assign mem_rd_en     = mem_rd_reg;
    assign mem_wr_en     = mem_wr_reg;
    assign mem_gm_or_lds = mem_gm_reg;
    assign mem_addr      = mem_addr_reg;
    assign mem_wr_data   = mem_data_reg;
    assign mem_tag_req   = mem_tag_reg;
    assign arb_busy      = (state_reg == ST_GRANT) || (state_reg == ST_RESP);
    assign arb_err       = err_reg;

endmodule

// File: tb/tb_lsu_mem_arbiter.sv
// Scoreboard testbench for lsu_mem_arbiter: directed scenarios plus random
// traffic against a requester/memory reference model. Expected responses are
// queued at grant time and popped by an independent response monitor.
// Define LSU_ARB_TIMEOUT_EN to also exercise the watchdog (TIMEOUT_CYCLES=16).
module tb_lsu_mem_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TW = 7;
`ifdef LSU_ARB_TIMEOUT_EN
    localparam int TMO = 16;
`else
    localparam int TMO = 1023;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_rd_en, req_wr_en, req_gm_or_lds, req_ack;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wr_data;
    logic [N*TW-1:0] req_tag;
    logic [DW-1:0]   req_rd_data, mem_wr_data, mem_rd_data;
    logic [TW-1:0]   req_tag_resp, mem_tag_req, mem_tag_resp;
    logic            mem_rd_en, mem_wr_en, mem_gm_or_lds, mem_ack, arb_busy, arb_err;
    logic [AW-1:0]   mem_addr;

    lsu_mem_arbiter #(
        .NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TAG_W(TW), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst(rst),
        .req_rd_en(req_rd_en), .req_wr_en(req_wr_en), .req_gm_or_lds(req_gm_or_lds),
        .req_addr(req_addr), .req_wr_data(req_wr_data), .req_tag(req_tag),
        .req_ack(req_ack), .req_rd_data(req_rd_data), .req_tag_resp(req_tag_resp),
        .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_gm_or_lds(mem_gm_or_lds),
        .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_tag_req(mem_tag_req),
        .mem_ack(mem_ack), .mem_rd_data(mem_rd_data), .mem_tag_resp(mem_tag_resp),
        .arb_busy(arb_busy), .arb_err(arb_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int            idx;
        logic [DW-1:0] data;
        logic [TW-1:0] tag;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Response monitor: every req_ack must match the oldest expected response
    always @(negedge clk) begin
        if (!rst && req_ack != '0) begin
            if (sbq.size() == 0) begin
                check("unexpected_ack", 64'(req_ack), 64'd0);
            end else begin
                mon_e = sbq.pop_front();
                check("ack_onehot", 64'(req_ack), 64'(N'(1) << mon_e.idx));
                check("ack_rd_data", 64'(req_rd_data), 64'(mon_e.data));
                check("ack_tag", 64'(req_tag_resp), 64'(mon_e.tag));
                $display("resp: req %0d data 0x%08h tag 0x%02h", mon_e.idx, req_rd_data, req_tag_resp);
            end
        end
    end

    // Reference model state: requesters, round-robin order, memory contents
    logic [N-1:0]  owed, owed_prev;
    int            hold [N];
    logic [AW-1:0] f_addr [N];
    logic [DW-1:0] f_data [N];
    logic [TW-1:0] f_tag  [N];
    logic          f_rd [N], f_wr [N], f_gm [N];
    int            last_w, cur_w, delay, issued;
    logic          in_flight, strobe_prev;
    logic [DW-1:0] cur_rdata;
    logic [DW-1:0] mem_model [logic [AW-1:0]];
    int            grant_log[$];

    function automatic logic [DW-1:0] mem_init(input logic [AW-1:0] a);
        return (a * 32'h0000_9E37) ^ 32'h5A5A_0000;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic rd, input logic wr, input logic gm,
                           input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [TW-1:0] t);
        req_rd_en[i]             = rd;
        req_wr_en[i]             = wr;
        req_gm_or_lds[i]         = gm;
        req_addr[i*AW +: AW]     = a;
        req_wr_data[i*DW +: DW]  = d;
        req_tag[i*TW +: TW]      = t;
    endtask

    task automatic clear_model();
        sbq.delete();
        grant_log.delete();
        owed = '0; owed_prev = '0;
        for (int i = 0; i < N; i++) hold[i] = 0;
        req_rd_en = '0; req_wr_en = '0; req_gm_or_lds = '0;
        req_addr = '0; req_wr_data = '0; req_tag = '0;
        mem_ack = 1'b0; mem_rd_data = '0; mem_tag_resp = '0;
        last_w = N - 1; in_flight = 1'b0; strobe_prev = 1'b0; delay = 0; cur_w = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_model();
        tick();
        tick();
        rst = 1'b0;
    endtask

    // One sampled cycle of the random environment
    task automatic step(input int p_issue, input int ntx);
        logic strobe;
        int   w;
        strobe = mem_rd_en | mem_wr_en;
        if (strobe && !strobe_prev) begin
            check("grant_pending", 64'(owed_prev != '0), 64'd1);
            w = -1;
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (last_w + k) % N;
                if (w < 0 && owed_prev[c]) w = c;
            end
            if (w >= 0) begin
                grant_log.push_back(w);
                check("grant_addr", 64'(mem_addr), 64'(f_addr[w]));
                check("grant_tag", 64'(mem_tag_req), 64'(f_tag[w]));
                check("grant_rd", 64'(mem_rd_en), 64'(f_rd[w]));
                check("grant_wr", 64'(mem_wr_en), 64'(f_wr[w]));
                check("grant_gm", 64'(mem_gm_or_lds), 64'(f_gm[w]));
                if (f_wr[w]) begin
                    check("grant_wdata", 64'(mem_wr_data), 64'(f_data[w]));
                    mem_model[f_addr[w]] = f_data[w];
                    cur_rdata = '0;
                end else begin
                    cur_rdata = mem_model.exists(f_addr[w]) ? mem_model[f_addr[w]] : mem_init(f_addr[w]);
                end
                sbq.push_back('{w, cur_rdata, f_tag[w]});
                $display("grant: req %0d %s addr 0x%08h tag 0x%02h", w, f_wr[w] ? "wr" : "rd", f_addr[w], f_tag[w]);
                last_w = w; cur_w = w; in_flight = 1'b1; delay = $urandom_range(0, 4);
            end
        end
        strobe_prev = strobe;

        // Memory responder; the granted requester also scribbles on its address
        if (in_flight) begin
            check("addr_hold", 64'(mem_addr), 64'(f_addr[cur_w]));
            if (delay == 0) begin
                mem_ack = 1'b1; mem_rd_data = cur_rdata; mem_tag_resp = mem_tag_req;
                in_flight = 1'b0;
            end else begin
                delay--;
                req_addr[cur_w*AW +: AW] = $urandom;
            end
        end else begin
            mem_ack = 1'b0; mem_rd_data = '0; mem_tag_resp = '0;
        end

        // Requesters: hold until acked, drop now or two cycles later, re-issue
        for (int i = 0; i < N; i++) begin
            if (req_ack[i]) begin
                owed[i] = 1'b0;
                hold[i] = ($urandom_range(0, 1) != 0) ? 2 : 0;
            end
            if (!owed[i]) begin
                if (req_rd_en[i] | req_wr_en[i]) begin
                    if (hold[i] == 0) begin
                        req_rd_en[i] = 1'b0; req_wr_en[i] = 1'b0;
                    end else begin
                        hold[i]--;
                    end
                end else if (issued < ntx && $urandom_range(0, 99) < p_issue) begin
                    f_rd[i]   = ($urandom_range(0, 1) != 0);
                    f_wr[i]   = ~f_rd[i];
                    f_gm[i]   = ($urandom_range(0, 1) != 0);
                    f_addr[i] = AW'($urandom_range(0, 15) * 4);
                    f_data[i] = $urandom;
                    f_tag[i]  = TW'($urandom);
                    set_req(i, f_rd[i], f_wr[i], f_gm[i], f_addr[i], f_data[i], f_tag[i]);
                    owed[i] = 1'b1;
                    issued++;
                end
            end
        end
        owed_prev = owed;
    endtask

    task automatic run_random(input int ntx, input int p_issue);
        int cyc;
        issued = 0;
        cyc = 0;
        while (!(issued >= ntx && owed == '0 && !in_flight && sbq.size() == 0 && !arb_busy) && cyc < 20000) begin
            tick();
            step(p_issue, ntx);
            cyc++;
        end
        check("random_done_in_budget", 64'(cyc < 20000), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_model();
        do_reset();

        // Reset state
        check("rst_busy", 64'(arb_busy), 64'd0);
        check("rst_err", 64'(arb_err), 64'd0);
        check("rst_strobes", 64'({mem_rd_en, mem_wr_en}), 64'd0);
        check("rst_req_ack", 64'(req_ack), 64'd0);

        // Single read: strobe one cycle after request, req_ack one after mem_ack
        set_req(2, 1'b1, 1'b0, 1'b1, 32'h100, 32'h0, 7'h15);
        tick();
        check("t1_rd_en", 64'(mem_rd_en), 64'd1);
        check("t1_wr_en", 64'(mem_wr_en), 64'd0);
        check("t1_addr", 64'(mem_addr), 64'h100);
        check("t1_tag", 64'(mem_tag_req), 64'h15);
        check("t1_busy", 64'(arb_busy), 64'd1);
        sbq.push_back('{2, 32'hCAFE, 7'h15});
        tick();
        tick();
        check("t1_no_early_ack", 64'(req_ack), 64'd0);
        mem_ack = 1'b1; mem_rd_data = 32'hCAFE; mem_tag_resp = 7'h15;
        tick();
        mem_ack = 1'b0;
        check("t1_req_ack", 64'(req_ack), 64'h4);
        check("t1_rd_data", 64'(req_rd_data), 64'hCAFE);
        check("t1_strobe_drop", 64'(mem_rd_en), 64'd0);
        check("t1_err", 64'(arb_err), 64'd0);
        req_rd_en[2] = 1'b0;
        tick();
        check("t1_ack_pulse", 64'(req_ack), 64'd0);
        check("t1_idle", 64'(arb_busy), 64'd0);

        // Spurious ack in IDLE
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("t4_spurious_err", 64'(arb_err), 64'd1);
        check("t4_spurious_busy", 64'(arb_busy), 64'd0);
        do_reset();
        check("t4_err_cleared", 64'(arb_err), 64'd0);

        // Tag mismatch: transaction still completes, error flagged
        set_req(2, 1'b1, 1'b0, 1'b0, 32'h104, 32'h0, 7'h15);
        tick();
        sbq.push_back('{2, 32'h1234, 7'h03});
        mem_ack = 1'b1; mem_rd_data = 32'h1234; mem_tag_resp = 7'h03;
        tick();
        mem_ack = 1'b0;
        req_rd_en[2] = 1'b0;
        check("t4_mismatch_ack", 64'(req_ack), 64'h4);
        check("t4_mismatch_err", 64'(arb_err), 64'd1);
        tick();
        check("t4_back_idle", 64'(arb_busy), 64'd0);

        // Read and write together: write forwarded, error flagged
        do_reset();
        set_req(1, 1'b1, 1'b1, 1'b1, 32'h200, 32'hBEEF, 7'h22);
        tick();
        check("rdwr_wr_en", 64'(mem_wr_en), 64'd1);
        check("rdwr_rd_en", 64'(mem_rd_en), 64'd0);
        check("rdwr_wdata", 64'(mem_wr_data), 64'hBEEF);
        check("rdwr_err", 64'(arb_err), 64'd1);
        sbq.push_back('{1, 32'h0, 7'h22});
        mem_ack = 1'b1; mem_rd_data = 32'h0; mem_tag_resp = 7'h22;
        tick();
        mem_ack = 1'b0;
        req_rd_en[1] = 1'b0; req_wr_en[1] = 1'b0;
        check("rdwr_ack", 64'(req_ack), 64'h2);
        tick();

        // Asynchronous reset in the middle of GRANT
        do_reset();
        set_req(3, 1'b1, 1'b0, 1'b1, 32'h300, 32'h0, 7'h11);
        tick();
        tick();
        check("t5_in_grant", 64'(mem_rd_en), 64'd1);
        #2;
        rst = 1'b1;
        clear_model();
        #1;
        check("t5_rst_strobe", 64'({mem_rd_en, mem_wr_en}), 64'd0);
        check("t5_rst_addr", 64'(mem_addr), 64'd0);
        check("t5_rst_tag", 64'(mem_tag_req), 64'd0);
        check("t5_rst_busy", 64'(arb_busy), 64'd0);
        check("t5_rst_err", 64'(arb_err), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        mem_ack = 1'b1; mem_rd_data = 32'h5555; mem_tag_resp = 7'h11;
        tick();
        mem_ack = 1'b0;
        check("t5_late_ack_err", 64'(arb_err), 64'd1);
        check("t5_late_ack_noack", 64'(req_ack), 64'd0);
        tick();
        check("t5_idle", 64'(arb_busy), 64'd0);

        // All requesters saturating: strict round-robin order 0,1,2,3,0,...
        do_reset();
        run_random(12, 100);
        check("rr_order_len", 64'(grant_log.size() >= 5), 64'd1);
        for (int k = 0; k < 5; k++) begin
            if (k < grant_log.size()) check($sformatf("rr_order_%0d", k), 64'(grant_log[k]), 64'(k % N));
        end
        check("rr_err", 64'(arb_err), 64'd0);

        // Sparse random traffic with random memory latency
        do_reset();
        run_random(60, 25);
        check("random_err", 64'(arb_err), 64'd0);
        check("random_queue_empty", 64'(sbq.size()), 64'd0);

`ifdef LSU_ARB_TIMEOUT_EN
        // Watchdog: no mem_ack, strobe held exactly TMO cycles
        begin
            int cnt;
            do_reset();
            set_req(0, 1'b0, 1'b1, 1'b1, 32'h40, 32'h77, 7'h2A);
            sbq.push_back('{0, 32'h0, 7'h2A});
            tick();
            cnt = 0;
            while ((mem_rd_en | mem_wr_en) && cnt < 100) begin
                cnt++;
                tick();
            end
            check("tmo_strobe_cycles", 64'(cnt), 64'(TMO));
            check("tmo_req_ack", 64'(req_ack), 64'h1);
            check("tmo_err", 64'(arb_err), 64'd1);
            req_wr_en[0] = 1'b0;
            tick();
        end
`endif

        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
